// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared gray-code state type and conversion helpers
package gray_pkg;

  // Helpers operate at a fixed maximum width; narrower codes are zero-extended,
  // which leaves the low bits of either conversion unchanged.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_bin_tracker_if.sv
// rtl/gray_bin_tracker_if.sv - gray input / decoded output bundle for the tracker
interface gray_bin_tracker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gry_in;
  logic             en;
  logic             err_clr;
  logic [WIDTH-1:0] bn_out;
  logic             bn_valid;
  logic             dir;
  logic             step_err;

  modport master (
    output gry_in, en, err_clr,
    input  bn_out, bn_valid, dir, step_err
  );

  modport slave (
    input  gry_in, en, err_clr,
    output bn_out, bn_valid, dir, step_err
  );
endinterface

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - WIDTH x SYNC_STAGES flop chain for an asynchronous gray bus
module gray_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_bin_tracker.sv
// rtl/gray_bin_tracker.sv - synchronizes, decodes and step-checks a gray-coded bus
module gray_bin_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_bin_tracker_if.slave  bus
);

  localparam int               CNT_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES);

  logic [WIDTH-1:0] w_gry_sync;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_delta;
  logic             w_step_up;
  logic             w_step_dn;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_bn;
  logic             r_valid;
  logic             r_dir;
  logic             r_err;

  gray_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.gry_in),
    .o_q   (w_gry_sync)
  );

  assign w_bin     = WIDTH'(gray2bin(GRAY_MAX_W'(w_gry_sync)));
  // Modular difference: wrap-around between all-ones and zero is a legal unit step.
  assign w_delta   = w_bin - r_bn;
  assign w_step_up = (w_delta == WIDTH'(1));
  assign w_step_dn = (w_delta == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_bn    <= '0;
      r_valid <= 1'b0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // A step error later in this block overrides the clear.
      if (bus.err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        INIT: begin
          if (!bus.en) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_bn    <= w_bin;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= TRACK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        TRACK: begin
          if (!bus.en) begin
            r_state <= HOLD;
          end else if (w_delta != '0) begin
            r_bn    <= w_bin;
            r_valid <= 1'b1;
            if (w_step_up) begin
              r_dir <= 1'b1;
            end else if (w_step_dn) begin
              r_dir <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Re-prime after a disable so motion while held is not judged as a step.
          if (bus.en) begin
            r_state <= INIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.bn_out   = r_bn;
  assign bus.bn_valid = r_valid;
  assign bus.dir      = r_dir;
  assign bus.step_err = r_err;

endmodule
